// File: rtl/gray_seq_checker.sv
// Monitors a gray-code counter stream: registers the binary decode, checks each
// transition for a legal +1 step, counts wraps and latches sticky error flags.
module gray_seq_checker #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [WIDTH-1:0]  Gray_In,
    input  logic              Overflow_In,
    input  logic              Err_Clear,
    output logic [WIDTH-1:0]  Binary,
    output logic              Valid,
    output logic              Step_Err,
    output logic              Ovf_Err,
    output logic [WRAP_W-1:0] Wrap_Count
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t             state;
    logic [WIDTH-1:0]   prev_gray;
    logic [WIDTH-1:0]   binary_q;
    logic               valid_q;
    logic               step_err_q;
    logic               ovf_err_q;
    logic [WRAP_W-1:0]  wrap_q;

    logic [WIDTH-1:0]   dec_in;
    logic [WIDTH-1:0]   dec_prev;
    logic               same;
    logic               inc_step;
    logic               wrap_step;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always_comb begin
        dec_in    = g2b(Gray_In);
        dec_prev  = g2b(prev_gray);
        same      = (Gray_In == prev_gray);
        inc_step  = (dec_in == dec_prev + WIDTH'(1));
        // a +1 step out of the all-ones binary value is the counter wrap
        wrap_step = inc_step && (&dec_prev);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            prev_gray  <= '0;
            binary_q   <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
            wrap_q     <= '0;
        end else begin
            if (En)
                binary_q <= dec_in;

            if (Err_Clear) begin
                // anything detected this cycle is dropped with the clear
                step_err_q <= 1'b0;
                ovf_err_q  <= 1'b0;
                valid_q    <= 1'b0;
                state      <= IDLE;
            end else if (!En) begin
                valid_q <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        prev_gray <= Gray_In;
                        valid_q   <= 1'b1;
                        state     <= TRACK;
                    end
                    TRACK: begin
                        prev_gray <= Gray_In;
                        if (same) begin
                            if (Overflow_In)
                                ovf_err_q <= 1'b1;
                        end else if (wrap_step) begin
                            if (wrap_q != '1)
                                wrap_q <= wrap_q + WRAP_W'(1);
                            if (!Overflow_In)
                                ovf_err_q <= 1'b1;
                        end else if (inc_step) begin
                            if (Overflow_In)
                                ovf_err_q <= 1'b1;
                        end else begin
                            step_err_q <= 1'b1;
                            state      <= FAULT;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Binary     = binary_q;
    assign Valid      = valid_q;
    assign Step_Err   = step_err_q;
    assign Ovf_Err    = ovf_err_q;
    assign Wrap_Count = wrap_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker: two instances (8-bit and 2-bit wrap
// counter) share one stimulus stream; expected values are hand-computed.
module tb_gray_seq_checker;

    logic       Clk = 1'b0;
    logic       Reset, En, Overflow_In, Err_Clear;
    logic [2:0] Gray_In;

    logic [2:0] bin8, bin2;
    logic       val8, val2, serr8, serr2, oerr8, oerr2;
    logic [7:0] wrap8;
    logic [1:0] wrap2;

    int tests = 0;
    int fails = 0;

    gray_seq_checker #(.WIDTH(3), .WRAP_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .En(En), .Gray_In(Gray_In),
        .Overflow_In(Overflow_In), .Err_Clear(Err_Clear),
        .Binary(bin8), .Valid(val8), .Step_Err(serr8), .Ovf_Err(oerr8),
        .Wrap_Count(wrap8)
    );

    gray_seq_checker #(.WIDTH(3), .WRAP_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .En(En), .Gray_In(Gray_In),
        .Overflow_In(Overflow_In), .Err_Clear(Err_Clear),
        .Binary(bin2), .Valid(val2), .Step_Err(serr2), .Ovf_Err(oerr2),
        .Wrap_Count(wrap2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive one sample, clock it, sample outputs 1 time unit after the edge
    task automatic cyc(input logic [2:0] g, input logic o);
        Gray_In     = g;
        Overflow_In = o;
        @(posedge Clk);
        #1;
    endtask

    // full legal lap starting from prev=000, ending on a flagged wrap to 000
    task automatic lap();
        cyc(3'b001, 0); cyc(3'b011, 0); cyc(3'b010, 0); cyc(3'b110, 0);
        cyc(3'b111, 0); cyc(3'b101, 0); cyc(3'b100, 0); cyc(3'b000, 1);
    endtask

    task automatic chk_status(input string tag, input logic v, input logic se,
                              input logic oe);
        chk({tag, "_valid"}, {31'b0, val8}, {31'b0, v});
        chk({tag, "_serr"},  {31'b0, serr8}, {31'b0, se});
        chk({tag, "_oerr"},  {31'b0, oerr8}, {31'b0, oe});
    endtask

    initial begin
        logic [2:0] seq [9];
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        Reset = 1; En = 0; Err_Clear = 0; Gray_In = '0; Overflow_In = 0;
        #2;
        cyc(3'b000, 0);
        chk("rst_bin", {29'b0, bin8}, 0);
        chk_status("rst", 0, 0, 0);
        chk("rst_wrap8", {24'b0, wrap8}, 0);
        chk("rst_wrap2", {30'b0, wrap2}, 0);

        // full count sequence; first sample is the re-sync
        Reset = 0; En = 1;
        for (int i = 0; i < 9; i++) begin
            cyc(seq[i], (i == 8));
            chk($sformatf("seq_bin%0d", i), {29'b0, bin8}, i % 8);
            if (i == 0) chk("seq_valid", {31'b0, val8}, 1);
        end
        chk("seq_wrap8", {24'b0, wrap8}, 1);
        chk("seq_wrap2", {30'b0, wrap2}, 1);
        chk_status("seq", 1, 0, 0);

        // hold at 011 for 5 cycles then step to 010
        cyc(3'b001, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b011, 0);
            chk($sformatf("hold_bin%0d", i), {29'b0, bin8}, 2);
        end
        cyc(3'b010, 0);
        chk("hold_step_bin", {29'b0, bin8}, 3);
        chk_status("hold", 1, 0, 0);

        // two-bit change 001 -> 010 goes to FAULT
        cyc(3'b110, 0); cyc(3'b111, 0); cyc(3'b101, 0); cyc(3'b100, 0);
        cyc(3'b000, 1);
        chk("lap2_wrap8", {24'b0, wrap8}, 2);
        cyc(3'b001, 0);
        cyc(3'b010, 0);
        chk("skip_bin", {29'b0, bin8}, 3);
        chk_status("skip", 1, 1, 0);
        cyc(3'b110, 0);
        chk("fault_bin", {29'b0, bin8}, 4);
        chk("fault_wrap8", {24'b0, wrap8}, 2);
        chk_status("fault", 1, 1, 0);
        Err_Clear = 1;
        cyc(3'b110, 0);
        Err_Clear = 0;
        chk_status("clr1", 0, 0, 0);
        cyc(3'b000, 0);
        chk_status("resync1", 1, 0, 0);

        // backward step 011 -> 001, then clear
        cyc(3'b001, 0); cyc(3'b011, 0); cyc(3'b001, 0);
        chk("back_bin", {29'b0, bin8}, 1);
        chk_status("back", 1, 1, 0);
        Err_Clear = 1;
        cyc(3'b001, 0);
        Err_Clear = 0;
        chk_status("clr2", 0, 0, 0);
        chk("clr2_wrap8", {24'b0, wrap8}, 2);
        cyc(3'b001, 0);
        chk_status("resync2", 1, 0, 0);

        // overflow flagged on a non-wrap step
        cyc(3'b011, 1);
        chk("ovf_step_bin", {29'b0, bin8}, 2);
        chk_status("ovf_step", 1, 0, 1);
        Err_Clear = 1;
        cyc(3'b011, 0);
        Err_Clear = 0;
        chk_status("clr3", 0, 0, 0);
        cyc(3'b011, 0);
        // overflow missing on a wrap; still tracking, wrap still counted
        cyc(3'b010, 0); cyc(3'b110, 0); cyc(3'b111, 0); cyc(3'b101, 0);
        cyc(3'b100, 0); cyc(3'b000, 0);
        chk_status("ovf_wrap", 1, 0, 1);
        chk("ovf_wrap8", {24'b0, wrap8}, 3);
        chk("ovf_wrap2", {30'b0, wrap2}, 3);
        cyc(3'b001, 0);
        chk_status("ovf_track", 1, 0, 1);
        Err_Clear = 1;
        cyc(3'b001, 0);
        Err_Clear = 0;
        cyc(3'b000, 0);

        // two more laps: 2-bit counter pinned at 3 after 5 wraps
        lap();
        lap();
        chk("sat_wrap8", {24'b0, wrap8}, 5);
        chk("sat_wrap2", {30'b0, wrap2}, 3);
        chk_status("sat", 1, 0, 0);

        // reset mid-sequence, resume on an arbitrary value
        cyc(3'b001, 0);
        Reset = 1;
        cyc(3'b011, 0);
        Reset = 0;
        chk("mrst_wrap8", {24'b0, wrap8}, 0);
        chk("mrst_wrap2", {30'b0, wrap2}, 0);
        chk("mrst_bin", {29'b0, bin8}, 0);
        chk_status("mrst", 0, 0, 0);
        cyc(3'b101, 1);
        chk("post_bin", {29'b0, bin8}, 6);
        chk_status("post", 1, 0, 0);
        cyc(3'b100, 0);
        cyc(3'b000, 1);
        chk("post_wrap2", {30'b0, wrap2}, 1);
        chk_status("post2", 1, 0, 0);

        // En low: Binary and wrap count held, Valid drops
        En = 0;
        cyc(3'b011, 0);
        chk("dis_bin", {29'b0, bin8}, 0);
        chk("dis_wrap8", {24'b0, wrap8}, 1);
        chk_status("dis", 0, 0, 0);
        chk("dis_bin2", {29'b0, bin2}, 0);
        chk("dis_serr2", {31'b0, serr2}, 0);
        chk("dis_oerr2", {31'b0, oerr2}, 0);
        chk("dis_val2", {31'b0, val2}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
